// File: rtl/word_bitwise_pkg.sv
// word_bitwise_pkg
// Shared definitions for the word_bitwise_pipe block: opcode width and the
// opcode enumeration decoded by word_bitwise_alu.
// Opcode 7 is ACC when WORD_BITWISE_ACC_EN is defined, otherwise PASS.
package word_bitwise_pkg;

    localparam int OPW = 3;

    typedef enum logic [OPW-1:0] {
        OP_FUSED    = 3'd0,
        OP_AND      = 3'd1,
        OP_OR       = 3'd2,
        OP_XOR      = 3'd3,
        OP_XNOR     = 3'd4,
        OP_NOT      = 3'd5,
        OP_MUX      = 3'd6,
        OP_ACC_PASS = 3'd7
    } op_e;

endpackage

// File: rtl/word_bitwise_alu.sv
// word_bitwise_alu
// Purely combinational opcode decode sitting between the S1 and S2 stages of
// word_bitwise_pipe.
// Configuration macro: WORD_BITWISE_ACC_EN (opcode 7 = acc ^ (a & b));
// without it opcode 7 passes a through.
// Ports:
//   op     in  OPW  opcode (op_e encoding)
//   a,b,c  in  W    operands
//   acc    in  W    accumulator value; the pipe ties it to zero when the
//                   accumulator feature is not built
//   result out W    selected bitwise result
module word_bitwise_alu
    import word_bitwise_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [OPW-1:0] op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [W-1:0]   c,
    input  logic [W-1:0]   acc,
    output logic [W-1:0]   result
);

    always_comb begin
        result = '0;
        case (op)
            OP_FUSED: result = ((a & b) ^ c) | ((~a & ~b) ~^ c);
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_XNOR:  result = a ~^ b;
            OP_NOT:   result = ~a;
            OP_MUX:   result = (a & c) | (b & ~c);
`ifdef WORD_BITWISE_ACC_EN
            OP_ACC_PASS: result = acc ^ (a & b);
`else
            // acc is held at zero in this build, so the XOR is a plain pass of a.
            OP_ACC_PASS: result = a ^ acc;
`endif
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/word_bitwise_pipe.sv
// word_bitwise_pipe
// Two-stage valid/ready pipeline computing a bitwise function of three
// W-bit operands. S1 registers opcode and operands, S2 registers the result
// and its all-zero flag. Full throughput, in-order, stall-safe.
// Configuration macro: WORD_BITWISE_ACC_EN adds a W-bit accumulator used by
// opcode 7 (ACC); without it opcode 7 is PASS and no accumulator exists.
// Ports:
//   clk          in   1    clock, rising edge
//   rst          in   1    asynchronous active-high reset
//   __in_valid   in   1    operand triple and opcode presented
//   __in_ready   out  1    block accepts the triple this cycle
//   __in_op      in   3    opcode
//   __in0..2     in   W    operands a, b, c
//   __out_valid  out  1    result presented
//   __out_ready  in   1    consumer takes the result this cycle
//   __out0       out  W    result word
//   __out_zero   out  1    __out0 is all zeros
module word_bitwise_pipe
    import word_bitwise_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           __in_valid,
    output logic           __in_ready,
    input  logic [OPW-1:0] __in_op,
    input  logic [W-1:0]   __in0,
    input  logic [W-1:0]   __in1,
    input  logic [W-1:0]   __in2,
    output logic           __out_valid,
    input  logic           __out_ready,
    output logic [W-1:0]   __out0,
    output logic           __out_zero
);

    logic           s1_valid;
    logic [OPW-1:0] s1_op;
    logic [W-1:0]   s1_a;
    logic [W-1:0]   s1_b;
    logic [W-1:0]   s1_c;

    logic           s2_valid;
    logic [W-1:0]   s2_result;
    logic           s2_zero;

    logic           adv1;
    logic           adv2;
    logic [W-1:0]   alu_result;
    logic [W-1:0]   acc_value;

    // A stage may advance when it is empty or the stage after it is moving.
    assign adv2       = !s2_valid || __out_ready;
    assign adv1       = !s1_valid || adv2;
    assign __in_ready = adv1;

    assign __out_valid = s2_valid;
    assign __out0      = s2_result;
    assign __out_zero  = s2_zero;

    // S1: operand data only loads on a real acceptance so that idle cycles
    // do not disturb the captured operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= '0;
        end else if (adv1) begin
            s1_valid <= __in_valid;
            if (__in_valid) begin
                s1_op <= __in_op;
                s1_a  <= __in0;
                s1_b  <= __in1;
                s1_c  <= __in2;
            end
        end
    end

    word_bitwise_alu #(
        .W (W)
    ) u_alu (
        .op     (s1_op),
        .a      (s1_a),
        .b      (s1_b),
        .c      (s1_c),
        .acc    (acc_value),
        .result (alu_result)
    );

    // S2: the result word only changes when a valid transaction moves in,
    // so __out0 keeps its last value while the stage is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_zero   <= 1'b1;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= alu_result;
                s2_zero   <= ~|alu_result;
            end
        end
    end

`ifdef WORD_BITWISE_ACC_EN
    logic [W-1:0] acc_q;

    // The accumulator updates at the same edge an ACC result enters S2, so
    // a following ACC op already sitting in S1 sees the new value on the
    // next cycle; back-to-back ACC ops chain without extra forwarding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (adv2 && s1_valid && (s1_op == OP_ACC_PASS)) begin
            acc_q <= alu_result;
        end
    end

    assign acc_value = acc_q;
`else
    assign acc_value = '0;
`endif

endmodule

// File: tb/tb_word_bitwise_pipe.sv
// tb_word_bitwise_pipe
// Directed bench for word_bitwise_pipe at W=8: reset state, every opcode
// class, two-cycle latency, backpressure with in-order drain, opcode 7 in
// whichever build is compiled (WORD_BITWISE_ACC_EN), and asynchronous reset
// mid-stream.
module tb_word_bitwise_pipe;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in0;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out0;
    logic         out_zero;

    int checks;
    int passes;

    word_bitwise_pipe #(
        .W (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .__in_valid  (in_valid),
        .__in_ready  (in_ready),
        .__in_op     (in_op),
        .__in0       (in0),
        .__in1       (in1),
        .__in2       (in2),
        .__out_valid (out_valid),
        .__out_ready (out_ready),
        .__out0      (out0),
        .__out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operand triple; it is taken at the next edge if ready.
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [W-1:0] c);
        in_valid = 1'b1;
        in_op    = op;
        in0      = a;
        in1      = b;
        in2      = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                               input logic [W-1:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    logic [W-1:0] exp_acc1;
    logic [W-1:0] exp_acc2;
    logic [W-1:0] exp_post_reset;

    initial begin
        checks    = 0;
        passes    = 0;
`ifdef WORD_BITWISE_ACC_EN
        exp_acc1       = 8'h0F;
        exp_acc2       = 8'h33;
        exp_post_reset = 8'h01;
`else
        exp_acc1       = 8'hFF;
        exp_acc2       = 8'h3C;
        exp_post_reset = 8'hFF;
`endif
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in0       = '0;
        in1       = '0;
        in2       = '0;
        out_ready = 1'b1;

        // Reset state
        #2;
        checkOutput("rst_out_valid", {7'b0, out_valid}, 8'h00);
        checkOutput("rst_out0", out0, 8'h00);
        checkOutput("rst_out_zero", {7'b0, out_zero}, 8'h01);
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("post_rst_in_ready", {7'b0, in_ready}, 8'h01);

        // FUSED with two-cycle latency
        applyStimulus(3'd0, 8'hF0, 8'h3C, 8'h0F);
        tick();
        in_valid = 1'b0;
        checkOutput("fused_lat1_valid", {7'b0, out_valid}, 8'h00);
        tick();
        checkOutput("fused_lat2_valid", {7'b0, out_valid}, 8'h01);
        checkOutput("fused_out0", out0, 8'hFF);
        checkOutput("fused_zero", {7'b0, out_zero}, 8'h00);

        // MUX then AND back to back
        applyStimulus(3'd6, 8'hAA, 8'h55, 8'hF0);
        tick();
        applyStimulus(3'd1, 8'h0F, 8'hF0, 8'h00);
        tick();
        in_valid = 1'b0;
        checkOutput("mux_out0", out0, 8'hA5);
        checkOutput("mux_zero", {7'b0, out_zero}, 8'h00);
        tick();
        checkOutput("and_out0", out0, 8'h00);
        checkOutput("and_zero", {7'b0, out_zero}, 8'h01);
        checkOutput("and_valid", {7'b0, out_valid}, 8'h01);
        tick();
        checkOutput("drain_valid", {7'b0, out_valid}, 8'h00);

        // Backpressure: OR, XOR, XNOR, NOT with the consumer stalled
        out_ready = 1'b0;
        applyStimulus(3'd2, 8'hC3, 8'h5A, 8'h00);
        tick();
        applyStimulus(3'd3, 8'hC3, 8'h5A, 8'h00);
        checkOutput("bp_ready_s1_only", {7'b0, in_ready}, 8'h01);
        tick();
        applyStimulus(3'd4, 8'hC3, 8'h5A, 8'h00);
        checkOutput("bp_ready_full", {7'b0, in_ready}, 8'h00);
        checkOutput("bp_or_out0", out0, 8'hDB);
        tick();
        checkOutput("bp_hold_out0", out0, 8'hDB);
        checkOutput("bp_hold_valid", {7'b0, out_valid}, 8'h01);
        checkOutput("bp_hold_ready", {7'b0, in_ready}, 8'h00);
        tick();
        checkOutput("bp_hold2_out0", out0, 8'hDB);
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", {7'b0, in_ready}, 8'h01);
        tick();
        checkOutput("bp_xor_out0", out0, 8'h99);
        applyStimulus(3'd5, 8'hC3, 8'h5A, 8'h00);
        tick();
        in_valid = 1'b0;
        checkOutput("bp_xnor_out0", out0, 8'h66);
        tick();
        checkOutput("bp_not_out0", out0, 8'h3C);
        checkOutput("bp_not_valid", {7'b0, out_valid}, 8'h01);
        tick();
        checkOutput("bp_drained", {7'b0, out_valid}, 8'h00);
        checkOutput("bp_out0_held", out0, 8'h3C);

        // Opcode 7 back to back (ACC or PASS depending on build)
        applyStimulus(3'd7, 8'hFF, 8'h0F, 8'h00);
        tick();
        applyStimulus(3'd7, 8'h3C, 8'hFF, 8'h00);
        tick();
        in_valid = 1'b0;
        checkOutput("op7_first", out0, exp_acc1);
        tick();
        checkOutput("op7_second", out0, exp_acc2);

        // Fill both stages, then reset asynchronously mid-cycle
        out_ready = 1'b0;
        applyStimulus(3'd1, 8'hFF, 8'hFF, 8'h00);
        tick();
        in_valid = 1'b0;
        checkOutput("full_in_ready", {7'b0, in_ready}, 8'h00);
        checkOutput("full_out_valid", {7'b0, out_valid}, 8'h01);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", {7'b0, out_valid}, 8'h00);
        checkOutput("async_rst_out0", out0, 8'h00);
        checkOutput("async_rst_zero", {7'b0, out_zero}, 8'h01);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        checkOutput("post_async_ready", {7'b0, in_ready}, 8'h01);
        checkOutput("post_async_valid", {7'b0, out_valid}, 8'h00);
        applyStimulus(3'd7, 8'hFF, 8'h01, 8'h00);
        tick();
        in_valid = 1'b0;
        tick();
        checkOutput("post_rst_op7", out0, exp_post_reset);
        checkOutput("post_rst_op7_valid", {7'b0, out_valid}, 8'h01);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
